chopper_timers: RTL and testbench
=================================

CHOPPER_TIMERS -- requirements
Module: chopper_timers

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: resetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: enable  in  1  driver enable; low forces both channels idle.
REQ-004 SHALL have ports: offtimer_en0, offtimer_en1  in  1 each  per-channel off-time start request (peak current reached).
REQ-005 SHALL have ports: phase_step  in  1  one-clk pulse when commutation step applied (both channels).
REQ-006 SHALL have ports: config_tick_div  in  8  prescaler; tick every config_tick_div+1 clks.
REQ-007 SHALL have ports: config_offtime  in  10  off-time reload, in ticks.
REQ-008 SHALL have ports: config_blanktime  in  8  blanking reload, in ticks.
REQ-009 SHALL have ports: config_minon  in  8  minimum on-time reload, in ticks.
REQ-010 SHALL have ports: off_timer0, off_timer1  out  10 each  remaining off time; nonzero = off phase.
REQ-011 SHALL have ports: blank_timer0, blank_timer1  out  8 each  remaining blanking time.
REQ-012 SHALL have ports: minimum_on_timer0, minimum_on_timer1  out  8 each  remaining minimum on time.
REQ-013 SHALL have ports: chop_state0, chop_state1  out  2 each  FSM state: 0 IDLE, 1 BLANK, 2 ON, 3 OFF.

Function
REQ-014 SHALL contain one shared prescaler counter; tick asserts one clk when counter equals config_tick_div, counter then returns to 0; div=0 gives tick every clk.
REQ-015 SHALL implement two identical independent channel FSMs (channel 0 uses offtimer_en0, channel 1 uses offtimer_en1).
REQ-016 IDLE: all channel timers 0; enable=1 -> BLANK next clk, blank_timer<=config_blanktime, minimum_on_timer<=config_minon.
REQ-017 BLANK: blank_timer decrements by 1 per tick; tick with blank_timer==1 -> ON with blank_timer 0; blank reload of 0 -> ON directly.
REQ-018 ON: offtimer_en=1 -> OFF, off_timer<=config_offtime; config_offtime==0 -> BLANK reload instead.
REQ-019 OFF: off_timer decrements per tick; tick with off_timer==1 -> BLANK with off_timer 0 and blank/min-on reloaded.
REQ-020 minimum_on_timer SHALL decrement per tick in BLANK, ON and OFF, saturating at 0, and SHALL NOT be cleared on OFF entry, so early off-time start stays visible downstream as a fault.
REQ-021 offtimer_en SHALL be ignored in IDLE, BLANK and OFF.
REQ-022 phase_step in BLANK or ON SHALL reload blank_timer and minimum_on_timer and enter or stay in BLANK; phase_step in OFF and IDLE SHALL be ignored.
REQ-023 Priority per clk: enable=0 > reload on state entry > offtimer_en > phase_step > tick decrement.
REQ-024 enable=0 in any state SHALL give IDLE and all timers 0 on the next clk; the prescaler keeps running.
REQ-025 Config inputs SHALL be sampled only at reload; mid-count changes SHALL NOT affect running timers.
REQ-026 All outputs SHALL be registered; chop_state SHALL match the timer values in the same cycle.
REQ-027 Timers SHALL never wrap below 0 or exceed their reload value.

Reset
REQ-028 resetn=0 SHALL clear prescaler to 0, both FSMs to IDLE, all timer outputs to 0, chop_state to 0, regardless of other inputs.
REQ-029 Reset mid-operation SHALL abort any count; after release, IDLE->BLANK needs enable=1 sampled on a clk.

Verification
REQ-030 div=0, blank=4, minon=10, enable rises: blank_timer 4,3,2,1,0 on consecutive clks; ON on clk with blank 0; minon reaches 0 after 10 ticks.
REQ-031 div=3, offtime=5, channel 0 in ON, offtimer_en0 pulse: off_timer0=5 for 4 clks, then 4..1, BLANK after 20 clks total; channel 1 unaffected.
REQ-032 minon=10, blank=2, offtimer_en0 at tick 4 in ON: OFF entered, minimum_on_timer0=6 while off_timer0 nonzero (fault condition visible).
REQ-033 Both channels in OFF, enable drops: next clk all six timers 0, chop_state 0; enable rises: both BLANK with reloads.
REQ-034 Channel in ON, offtimer_en and phase_step same clk: OFF entered, blank not reloaded; phase_step during OFF: no effect.
REQ-035 Reset asserted with off_timer0=300: next clk all outputs 0, IDLE; offtime=0 edge: offtimer_en in ON -> BLANK reload, off_timer stays 0.

Source files
------------

// File: rtl/chopper_timers.sv
// chopper_timers: shared tick prescaler plus two independent chopper channel
// FSMs (IDLE/BLANK/ON/OFF) with off-time, blanking and minimum-on timers.
// Ports:
//   clk, resetn            - clock, synchronous active-low reset
//   enable                 - driver enable; low forces both channels idle
//   offtimer_en0/1         - per-channel off-time start request (peak current)
//   phase_step             - commutation step pulse, applies to both channels
//   config_tick_div        - prescaler; one tick every config_tick_div+1 clks
//   config_offtime         - off-time reload in ticks
//   config_blanktime       - blanking reload in ticks
//   config_minon           - minimum on-time reload in ticks
//   off_timer0/1           - remaining off time (nonzero = off phase)
//   blank_timer0/1         - remaining blanking time
//   minimum_on_timer0/1    - remaining minimum on time
//   chop_state0/1          - 0 IDLE, 1 BLANK, 2 ON, 3 OFF

// One chopper channel: state register plus its three timers.
module chopper_channel (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       tick,
  input  logic       offtimer_en,
  input  logic       phase_step,
  input  logic [9:0] cfg_offtime,
  input  logic [7:0] cfg_blanktime,
  input  logic [7:0] cfg_minon,
  output logic [9:0] off_timer,
  output logic [7:0] blank_timer,
  output logic [7:0] minimum_on_timer,
  output logic [1:0] chop_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;
  localparam logic [1:0] ST_OFF   = 2'd3;

  logic [1:0] state_q, state_d;
  logic [9:0] off_q, off_d;
  logic [7:0] blank_q, blank_d;
  logic [7:0] minon_q, minon_d;

  logic       reload_c;
  logic [7:0] minon_dec_c;

  // Saturating decrement of the minimum-on timer.
  assign minon_dec_c = (minon_q != 8'd0) ? 8'(minon_q - 8'd1) : 8'd0;

  // Next-state and timer update; reload_c collects every path that restarts
  // the blanking window so the reload values are written in one place.
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    blank_d  = blank_q;
    minon_d  = minon_q;
    reload_c = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      off_d   = 10'd0;
      blank_d = 8'd0;
      minon_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          reload_c = 1'b1;
        end
        ST_BLANK: begin
          if (phase_step) begin
            reload_c = 1'b1;
          end else if (tick) begin
            minon_d = minon_dec_c;
            if (blank_q <= 8'd1) begin
              blank_d = 8'd0;
              state_d = ST_ON;
            end else begin
              blank_d = 8'(blank_q - 8'd1);
            end
          end
        end
        ST_ON: begin
          // Accepting the off request holds minon so an early start stays visible.
          if (offtimer_en) begin
            if (cfg_offtime == 10'd0) begin
              reload_c = 1'b1;
            end else begin
              state_d = ST_OFF;
              off_d   = cfg_offtime;
            end
          end else if (phase_step) begin
            reload_c = 1'b1;
          end else if (tick) begin
            minon_d = minon_dec_c;
          end
        end
        default: begin
          if (tick) begin
            if (off_q <= 10'd1) begin
              reload_c = 1'b1;
            end else begin
              off_d   = 10'(off_q - 10'd1);
              minon_d = minon_dec_c;
            end
          end
        end
      endcase

      // A zero blanking reload skips straight to ON so state matches timers.
      if (reload_c) begin
        state_d = (cfg_blanktime == 8'd0) ? ST_ON : ST_BLANK;
        off_d   = 10'd0;
        blank_d = cfg_blanktime;
        minon_d = cfg_minon;
      end
    end
  end

  // Channel registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      off_q   <= 10'd0;
      blank_q <= 8'd0;
      minon_q <= 8'd0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      blank_q <= blank_d;
      minon_q <= minon_d;
    end
  end

  assign off_timer        = off_q;
  assign blank_timer      = blank_q;
  assign minimum_on_timer = minon_q;
  assign chop_state       = state_q;

endmodule

module chopper_timers (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       offtimer_en0,
  input  logic       offtimer_en1,
  input  logic       phase_step,
  input  logic [7:0] config_tick_div,
  input  logic [9:0] config_offtime,
  input  logic [7:0] config_blanktime,
  input  logic [7:0] config_minon,
  output logic [9:0] off_timer0,
  output logic [9:0] off_timer1,
  output logic [7:0] blank_timer0,
  output logic [7:0] blank_timer1,
  output logic [7:0] minimum_on_timer0,
  output logic [7:0] minimum_on_timer1,
  output logic [1:0] chop_state0,
  output logic [1:0] chop_state1
);

  logic [7:0] div_cnt_q, div_cnt_d;
  logic       tick_c;

  // Shared prescaler; keeps running regardless of enable.
  always_comb begin
    tick_c    = (div_cnt_q == config_tick_div);
    div_cnt_d = tick_c ? 8'd0 : 8'(div_cnt_q + 8'd1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cnt_q <= 8'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  chopper_channel u_ch0 (
    .clk              (clk),
    .resetn           (resetn),
    .enable           (enable),
    .tick             (tick_c),
    .offtimer_en      (offtimer_en0),
    .phase_step       (phase_step),
    .cfg_offtime      (config_offtime),
    .cfg_blanktime    (config_blanktime),
    .cfg_minon        (config_minon),
    .off_timer        (off_timer0),
    .blank_timer      (blank_timer0),
    .minimum_on_timer (minimum_on_timer0),
    .chop_state       (chop_state0)
  );

  chopper_channel u_ch1 (
    .clk              (clk),
    .resetn           (resetn),
    .enable           (enable),
    .tick             (tick_c),
    .offtimer_en      (offtimer_en1),
    .phase_step       (phase_step),
    .cfg_offtime      (config_offtime),
    .cfg_blanktime    (config_blanktime),
    .cfg_minon        (config_minon),
    .off_timer        (off_timer1),
    .blank_timer      (blank_timer1),
    .minimum_on_timer (minimum_on_timer1),
    .chop_state       (chop_state1)
  );

endmodule

// File: tb/tb_chopper_timers.sv
// Directed bench for chopper_timers: reset, blanking/on sequence, off-time
// with prescaler, early off-time fault visibility, priorities, enable drop,
// reset mid-count and zero reload edge cases.
module tb_chopper_timers;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic       offtimer_en0;
  logic       offtimer_en1;
  logic       phase_step;
  logic [7:0] config_tick_div;
  logic [9:0] config_offtime;
  logic [7:0] config_blanktime;
  logic [7:0] config_minon;
  logic [9:0] off_timer0, off_timer1;
  logic [7:0] blank_timer0, blank_timer1;
  logic [7:0] minimum_on_timer0, minimum_on_timer1;
  logic [1:0] chop_state0, chop_state1;

  int errors = 0;
  int checks = 0;

  chopper_timers dut (
    .clk               (clk),
    .resetn            (resetn),
    .enable            (enable),
    .offtimer_en0      (offtimer_en0),
    .offtimer_en1      (offtimer_en1),
    .phase_step        (phase_step),
    .config_tick_div   (config_tick_div),
    .config_offtime    (config_offtime),
    .config_blanktime  (config_blanktime),
    .config_minon      (config_minon),
    .off_timer0        (off_timer0),
    .off_timer1        (off_timer1),
    .blank_timer0      (blank_timer0),
    .blank_timer1      (blank_timer1),
    .minimum_on_timer0 (minimum_on_timer0),
    .minimum_on_timer1 (minimum_on_timer1),
    .chop_state0       (chop_state0),
    .chop_state1       (chop_state1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full check of one channel: state, off, blank, minimum-on.
  task automatic chan(input string tag, input int ch, input int st, input int off,
                      input int bl, input int mo);
    if (ch == 0) begin
      chk({tag, ".st0"}, int'(chop_state0), st);
      chk({tag, ".off0"}, int'(off_timer0), off);
      chk({tag, ".blank0"}, int'(blank_timer0), bl);
      chk({tag, ".minon0"}, int'(minimum_on_timer0), mo);
    end else begin
      chk({tag, ".st1"}, int'(chop_state1), st);
      chk({tag, ".off1"}, int'(off_timer1), off);
      chk({tag, ".blank1"}, int'(blank_timer1), bl);
      chk({tag, ".minon1"}, int'(minimum_on_timer1), mo);
    end
  endtask

  initial begin
    int bl_exp[5];
    bl_exp = '{4, 3, 2, 1, 0};

    resetn           = 1'b0;
    enable           = 1'b1;
    offtimer_en0     = 1'b0;
    offtimer_en1     = 1'b0;
    phase_step       = 1'b0;
    config_tick_div  = 8'd0;
    config_offtime   = 10'd7;
    config_blanktime = 8'd4;
    config_minon     = 8'd10;

    // Reset with enable high: everything idle and zero.
    step();
    step();
    chan("reset", 0, 0, 0, 0, 0);
    chan("reset", 1, 0, 0, 0, 0);

    // Blanking then ON with div=0.
    resetn = 1'b1;
    enable = 1'b0;
    step();
    chk("idle_en0", int'(chop_state0), 0);
    enable = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("blank_seq.blank0", int'(blank_timer0), bl_exp[i]);
      chk("blank_seq.st0", int'(chop_state0), (i < 4) ? 1 : 2);
      chk("blank_seq.minon0", int'(minimum_on_timer0), 10 - i);
      if (i < 4) step();
    end
    chan("on_entry_ch1", 1, 2, 0, 0, 6);
    for (int i = 0; i < 6; i++) step();
    chan("minon_zero", 0, 2, 0, 0, 0);
    step();
    chk("minon_sat", int'(minimum_on_timer0), 0);

    // Early off-time start: minimum-on still nonzero during OFF.
    enable = 1'b0;
    config_blanktime = 8'd2;
    step();
    chan("idle_again", 0, 0, 0, 0, 0);
    enable = 1'b1;
    step();
    chan("blank2", 0, 1, 0, 2, 10);
    step();
    step();
    step();
    step();
    chan("on_minon6", 0, 2, 0, 0, 6);
    offtimer_en0 = 1'b1;
    step();
    offtimer_en0 = 1'b0;
    chan("fault_off", 0, 3, 7, 0, 6);
    chan("fault_ch1", 1, 2, 0, 0, 5);
    step();
    chan("off_dec", 0, 3, 6, 0, 5);

    // phase_step ignored in OFF, reloads BLANK from ON.
    phase_step = 1'b1;
    step();
    phase_step = 1'b0;
    chan("ps_off", 0, 3, 5, 0, 4);
    chan("ps_on", 1, 1, 0, 2, 10);
    step();
    step();
    chan("ch1_on", 1, 2, 0, 0, 8);
    // offtimer_en beats phase_step in ON.
    offtimer_en1 = 1'b1;
    phase_step   = 1'b1;
    step();
    offtimer_en1 = 1'b0;
    phase_step   = 1'b0;
    chan("prio_ch1", 1, 3, 7, 0, 8);
    chan("prio_ch0", 0, 3, 2, 0, 1);

    // Enable drop with both channels in OFF, then re-enable.
    enable = 1'b0;
    step();
    chan("en_drop", 0, 0, 0, 0, 0);
    chan("en_drop", 1, 0, 0, 0, 0);
    config_blanktime = 8'd3;
    config_minon     = 8'd5;
    enable           = 1'b1;
    step();
    chan("en_rise", 0, 1, 0, 3, 5);
    chan("en_rise", 1, 1, 0, 3, 5);

    // Off-time with div=3; prescaler counter sits at 0 while div=0.
    step();
    step();
    step();
    chan("pre_div", 0, 2, 0, 0, 2);
    config_tick_div = 8'd3;
    config_offtime  = 10'd5;
    step();
    step();
    step();
    chk("no_tick_minon", int'(minimum_on_timer0), 2);
    offtimer_en0 = 1'b1;
    step();
    offtimer_en0 = 1'b0;
    chan("div3_entry", 0, 3, 5, 0, 2);
    chan("div3_ch1", 1, 2, 0, 0, 1);
    for (int i = 1; i <= 20; i++) begin
      if (i == 2) config_offtime = 10'd9;
      step();
      chk("div3_off0", int'(off_timer0), (i < 20) ? 5 - i / 4 : 0);
      chk("div3_st0", int'(chop_state0), (i < 20) ? 3 : 1);
      chk("div3_ch1_st", int'(chop_state1), 2);
    end
    chan("div3_exit", 0, 1, 0, 3, 5);

    // Reset with off_timer0 = 300.
    config_tick_div = 8'd0;
    config_offtime  = 10'd300;
    step();
    step();
    step();
    offtimer_en0 = 1'b1;
    step();
    offtimer_en0 = 1'b0;
    chk("off300", int'(off_timer0), 300);
    resetn = 1'b0;
    step();
    chan("mid_reset", 0, 0, 0, 0, 0);
    chan("mid_reset", 1, 0, 0, 0, 0);
    resetn = 1'b1;
    step();
    chan("post_reset", 0, 1, 0, 3, 5);

    // Zero off-time reload: offtimer_en in ON reloads blanking.
    step();
    step();
    step();
    chk("pre_zero_st", int'(chop_state0), 2);
    config_offtime = 10'd0;
    offtimer_en0   = 1'b1;
    step();
    offtimer_en0 = 1'b0;
    chan("off_zero", 0, 1, 0, 3, 5);

    // Zero blanking reload enters ON directly.
    enable = 1'b0;
    step();
    config_blanktime = 8'd0;
    enable = 1'b1;
    step();
    chan("blank_zero", 0, 2, 0, 0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
